// File: rtl/instr_sequencer.sv
// Program-memory instruction source for the control unit: fetch, issue with a one-cycle run strobe, wait for done.
// Optional WATCHDOG_EN macro: WAIT times out into HALT with err set when done never arrives.
module instr_sequencer #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32,
    parameter int IW     = 9
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [IW-1:0]     load_data,
    input  logic              start,
    input  logic              done,
    output logic [IW-1:0]     iin,
    output logic [IW-1:0]     din,
    output logic              run,
    output logic              busy,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic [7:0]        instr_count,
    output logic              err
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_HALT} state_t;

    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t            state;
    logic [IW-1:0]     mem [DEPTH];
    logic [IW-1:0]     word;
    logic [IW-1:0]     word_next;
    logic [ADDR_W-1:0] pc_inc1;
    logic [ADDR_W-1:0] pc_inc2;
    logic [2:0]        opcode;

    // pc arithmetic wraps naturally at ADDR_W bits, so mvi at the last word reads its immediate from 0
    assign pc_inc1   = pc + ADDR_W'(1);
    assign pc_inc2   = pc + ADDR_W'(2);
    assign word      = mem[pc];
    assign word_next = mem[pc_inc1];
    assign opcode    = word[IW-1:IW-3];

    always_ff @(posedge clock) begin
        if (load_we && (state == S_IDLE || state == S_HALT))
            mem[load_addr] <= load_data;
    end

`ifdef WATCHDOG_EN
    logic [2:0] wd;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= S_IDLE;
            iin         <= '0;
            din         <= '0;
            pc          <= '0;
            instr_count <= '0;
            run         <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
`ifdef WATCHDOG_EN
            err         <= 1'b0;
            wd          <= '0;
`endif
        end else begin
            run <= 1'b0;
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc          <= '0;
                        instr_count <= '0;
                        halted      <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_FETCH;
`ifdef WATCHDOG_EN
                        err         <= 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    if (opcode == OP_HALT) begin
                        busy   <= 1'b0;
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        iin   <= word;
                        run   <= 1'b1;
                        state <= S_ISSUE;
                        if (opcode == OP_MVI) begin
                            din <= word_next;
                            pc  <= pc_inc2;
                        end else begin
                            din <= '0;
                            pc  <= pc_inc1;
                        end
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
`ifdef WATCHDOG_EN
                    wd    <= '0;
`endif
                end
                S_WAIT: begin
                    if (done) begin
                        if (instr_count != 8'hFF)
                            instr_count <= instr_count + 8'd1;
                        state <= S_FETCH;
                    end
`ifdef WATCHDOG_EN
                    // seventh silent WAIT cycle gives up on the control unit
                    else if (wd == 3'd6) begin
                        err    <= 1'b1;
                        halted <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_HALT;
                    end else begin
                        wd <= wd + 3'd1;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer.
module tb_instr_sequencer;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       load_we = 1'b0;
    logic [4:0] load_addr = '0;
    logic [8:0] load_data = '0;
    logic       start = 1'b0;
    logic       done = 1'b0;
    logic [8:0] iin;
    logic [8:0] din;
    logic       run;
    logic       busy;
    logic       halted;
    logic [4:0] pc;
    logic [7:0] instr_count;
    logic       err;

    int total = 0;
    int bad = 0;

    instr_sequencer dut (
        .clock(clock), .resetn(resetn), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .start(start), .done(done), .iin(iin), .din(din),
        .run(run), .busy(busy), .halted(halted), .pc(pc), .instr_count(instr_count),
        .err(err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [4:0] a, input logic [8:0] d);
        load_we = 1'b1; load_addr = a; load_data = d;
        tick();
        load_we = 1'b0;
    endtask

    task automatic wait_run(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (run === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Leaves the bench in the FETCH cycle that follows the done edge.
    task automatic answer();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        total++; if ({iin, din} !== 18'h0) begin bad++; $display("FAIL reset_iin_din got=%h want=0", {iin, din}); end
        total++; if ({run, busy, halted, err} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {run, busy, halted, err}); end
        total++; if ({pc, instr_count} !== 13'h0) begin bad++; $display("FAIL reset_pc_cnt got=%h want=0", {pc, instr_count}); end
    endtask

    task automatic test_program();
        logic [8:0] exp_i [3] = '{9'h040, 9'h048, 9'h081};
        logic [8:0] exp_d [3] = '{9'h005, 9'h003, 9'h000};
        logic [4:0] exp_p [3] = '{5'd2, 5'd4, 5'd5};
        load(5'd0, 9'h040); load(5'd1, 9'h005); load(5'd2, 9'h048);
        load(5'd3, 9'h003); load(5'd4, 9'h081); load(5'd5, 9'h1C0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            total++; if (run !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL prog_fetch%0d run=%b busy=%b want run=0 busy=1", j, run, busy); end
            tick();
            total++; if (run !== 1'b1) begin bad++; $display("FAIL prog_run%0d got=%b want=1", j, run); end
            total++; if (iin !== exp_i[j] || din !== exp_d[j]) begin bad++; $display("FAIL prog_word%0d got=%h/%h want=%h/%h", j, iin, din, exp_i[j], exp_d[j]); end
            total++; if (pc !== exp_p[j]) begin bad++; $display("FAIL prog_pc%0d got=%0d want=%0d", j, pc, exp_p[j]); end
            answer();
        end
        tick();
        total++; if (halted !== 1'b1 || busy !== 1'b0 || run !== 1'b0) begin bad++; $display("FAIL prog_halt got h=%b b=%b r=%b want 1/0/0", halted, busy, run); end
        total++; if (pc !== 5'd5 || instr_count !== 8'd3) begin bad++; $display("FAIL prog_final got pc=%0d cnt=%0d want 5/3", pc, instr_count); end
    endtask

    task automatic test_latency_and_busy_ignore();
        bit ok;
        load(5'd1, 9'h000); load(5'd2, 9'h000); load(5'd3, 9'h1C0);
        // write word 0 in the same cycle as start
        load_we = 1'b1; load_addr = 5'd0; load_data = 9'h081; start = 1'b1;
        tick();
        load_we = 1'b0; start = 1'b0;
        total++; if (run !== 1'b0) begin bad++; $display("FAIL lat_k1 run got=%b want=0", run); end
        tick();
        total++; if (run !== 1'b1 || iin !== 9'h081 || din !== 9'h000) begin bad++; $display("FAIL lat_k2 got run=%b iin=%h din=%h want 1/081/000", run, iin, din); end
        for (int i = 0; i < 5; i++) begin
            load_we = (i == 1); load_addr = 5'd3; load_data = 9'h010;
            start = (i == 2);
            tick();
            total++; if (run !== 1'b0 || iin !== 9'h081 || pc !== 5'd1) begin bad++; $display("FAIL wait_hold%0d got run=%b iin=%h pc=%0d want 0/081/1", i, run, iin, pc); end
        end
        load_we = 1'b0; start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            if (j > 0) begin
                wait_run(ok);
                total++; if (!ok) begin bad++; $display("FAIL busy_run%0d timeout got=0 want=1", j); end
            end
            answer();
        end
        tick();
        total++; if (halted !== 1'b1 || pc !== 5'd3 || instr_count !== 8'd3) begin bad++; $display("FAIL write_ignored got h=%b pc=%0d cnt=%0d want 1/3/3", halted, pc, instr_count); end
    endtask

    task automatic test_wrap_and_reset();
        bit ok;
        load(5'd0, 9'h00A);
        for (int a = 1; a < 31; a++) load(a[4:0], 9'h000);
        load(5'd31, 9'h040);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            wait_run(ok);
            if (!ok) begin
                total++; bad++; $display("FAIL wrap_run%0d timeout got=0 want=1", i);
                break;
            end
            if (i == 0) begin
                total++; if (iin !== 9'h00A || din !== 9'h000) begin bad++; $display("FAIL wrap_first got=%h/%h want=00a/000", iin, din); end
            end
            if (i == 31) begin
                total++; if (iin !== 9'h040 || din !== 9'h00A) begin bad++; $display("FAIL wrap_mvi got=%h/%h want=040/00a", iin, din); end
                total++; if (pc !== 5'd1) begin bad++; $display("FAIL wrap_pc got=%0d want=1", pc); end
            end
            answer();
        end
        wait_run(ok);
        tick();
        total++; if (!ok || busy !== 1'b1 || iin !== 9'h000) begin bad++; $display("FAIL pre_reset_wait got ok=%b busy=%b iin=%h want 1/1/000", ok, busy, iin); end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        total++; if ({iin, din, pc, instr_count} !== 31'h0 || {run, busy, halted, err} !== 4'b0) begin bad++; $display("FAIL midreset got=%h/%h/%0d/%0d/%b want all 0", iin, din, pc, instr_count, {run, busy, halted, err}); end
        done = 1'b1;
        tick();
        done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (run !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL post_reset_idle%0d got run=%b busy=%b want 0/0", i, run, busy); end
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        total++; if (run !== 1'b1 || iin !== 9'h00A) begin bad++; $display("FAIL rerun got run=%b iin=%h want 1/00a", run, iin); end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_watchdog();
        bit ok;
        load(5'd0, 9'h081);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_run(ok);
        total++; if (!ok) begin bad++; $display("FAIL wd_run timeout got=0 want=1"); end
        for (int i = 0; i < 20; i++) tick();
`ifdef WATCHDOG_EN
        total++; if (err !== 1'b1 || halted !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL wd_trip got err=%b h=%b b=%b want 1/1/0", err, halted, busy); end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL wd_clear got err=%b busy=%b want 0/1", err, busy); end
`else
        total++; if (err !== 1'b0 || halted !== 1'b0 || busy !== 1'b1 || iin !== 9'h081) begin bad++; $display("FAIL wd_wait got err=%b h=%b b=%b iin=%h want 0/0/1/081", err, halted, busy, iin); end
`endif
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_program();
        test_latency_and_busy_ignore();
        test_wrap_and_reset();
        test_watchdog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction source for the simple processor's control unit: holds a small program memory and fetches 9-bit instruction words.
- Drives iin/din with a one-cycle run strobe, then waits for the done handshake before fetching the next word.
- Sits upstream of the control unit, in place of the manual switch-driven instruction entry; stops on a HALT word.
- Instruction format: opcode iin[8:6], rx iin[5:3], ry iin[2:0].
- Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 111 HALT (sequencer-only, never issued).

Parameters:
- ADDR_W, 5, program address width.
- DEPTH, 32, program words (= 2**ADDR_W).
- IW, 9, instruction/data word width.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- resetn  input  1  synchronous active-low reset, sampled on rising edge of clock.
- load_we  input  1  program write strobe.
- load_addr  input  ADDR_W  program write address.
- load_data  input  IW  program write data.
- start  input  1  begin execution at address 0.
- done  input  1  control unit has finished the issued instruction.
- iin  output  IW  instruction word to control unit.
- din  output  IW  immediate data word (mvi only, else 0).
- run  output  1  one-cycle issue strobe.
- busy  output  1  high in FETCH/ISSUE/WAIT.
- halted  output  1  high in HALT.
- pc  output  ADDR_W  address of next word to fetch.
- instr_count  output  8  completed instructions, saturating at 255.
- err  output  1  watchdog error flag (see Optional Feature).

Behaviour:
- Reset (resetn=0 at edge): state IDLE; iin, din, pc, instr_count, run, busy, halted, err all 0. Program memory not cleared. Reset mid-operation abandons the instruction in flight immediately; no run is issued afterward.
- Memory: DEPTH x IW register array, asynchronous read. Write on load_we only in IDLE or HALT; writes while busy are ignored.
- IDLE/HALT: start=1 -> pc<=0, instr_count<=0, err<=0, halted<=0, go FETCH. start while busy is ignored.
- FETCH (1 cycle), decode w=mem[pc]:
  - opcode 111: go HALT; pc keeps the HALT address; no run.
  - opcode 001 (mvi): iin<=w, din<=mem[pc+1], pc<=pc+2; go ISSUE.
  - otherwise: iin<=w, din<=0, pc<=pc+1; go ISSUE.
  - Undefined opcodes 100-110 are issued unchanged.
- ISSUE (1 cycle): run=1. done is ignored in this cycle. Go WAIT.
- WAIT: run=0; iin/din held stable. On done=1: instr_count<=instr_count+1 (hold at 255), go FETCH.
- Latency: start sampled at edge k -> FETCH in cycle k+1 -> run high in cycle k+2. After done sampled at edge m, the next run is high in cycle m+2.
- pc arithmetic is modulo DEPTH. Wrap DEPTH-1 -> 0. mvi at DEPTH-1 takes its immediate from address 0, and pc becomes 1.
- done outside WAIT has no effect.
- start and load_we in the same cycle in IDLE: the write occurs, and FETCH reads the updated word on the next cycle.
- run is never high for two consecutive cycles.

Optional Feature:
- Macro WATCHDOG_EN.
- Defined: 3-bit watchdog counter, cleared on entering WAIT, increments each WAIT cycle without done. Reaching 7 -> err<=1, go HALT. err stays set until start or reset.
- Undefined: no counter; WAIT waits indefinitely; err tied 0.

Test Plan:
- Program {040,005,048,003,081,1C0} at 0-5, start -> run pulses with (iin,din) = (040,005), (048,003), (081,000), each answered by done two cycles after run. Final state: halted=1, pc=5, instr_count=3, busy=0.
- start at edge k with mem[0]=081 -> run=1 exactly in cycle k+2. done held 0 for 5 cycles -> iin stays 081, no further run.
- mvi 040 at address 31, 00A at address 0, pc forced via program starting with NOPs (mv 000) to reach 31 -> din=00A, next fetch at pc=1.
- Reset asserted during WAIT -> next edge: all outputs 0, state IDLE. Subsequent done pulse causes no run. Memory contents retained (re-start reruns the same program).
- load_we in WAIT to address 3 -> memory unchanged (readback by execution). start pulsed while busy -> pc unaffected.
- WATCHDOG_EN: issue 081, never return done -> err=1 and halted=1 on the 7th WAIT cycle. Without the macro, still waiting after 20 cycles, err=0.
